// File: rtl/uart_reg_bank.sv
// Register-side responder for the UART command path: decodes read/write
// commands, executes them against a local 32-bit register bank and returns a one-cycle response.
module uart_reg_bank #(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] ID_VALUE  = 32'h5647_4131,
    parameter logic [31:0] RST_VALUE = 32'h0000_0000
) (
    input  logic                     CLK_100M,
    input  logic                     SYS_RST_N,
    input  logic [1:0]               UART_STATE,
    input  logic [31:0]              UART_DATA,
    input  logic [7:0]               UART_ADDR,
    output logic [1:0]               REG_STATE,
    output logic [31:0]              REG_DATA,
    output logic [NUM_REGS*32-1:0]   REG_Q,
    output logic                     REG_WR_STB,
    output logic [7:0]               REG_WR_ADDR
);

    localparam int         AW         = $clog2(NUM_REGS);
    localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    localparam logic [1:0] RSP_NONE  = 2'b00;
    localparam logic [1:0] RSP_WR_OK = 2'b01;
    localparam logic [1:0] RSP_RD_OK = 2'b10;
    localparam logic [1:0] RSP_ERR   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_EXEC} state_e;
    typedef enum logic [1:0] {CL_ERR, CL_WRITE, CL_READ} class_e;

    state_e        state_q, state_d;
    class_e        class_q, class_d;
    logic [1:0]    prev_q;
    logic [1:0]    cmd_q;
    logic [7:0]    addr_q;
    logic [31:0]   data_q;
    logic          req;
    logic          addr_ok;
    logic [AW-1:0] addr_idx;

    logic [31:0]   regs_q [NUM_REGS-1:1];
    logic [31:0]   bank   [NUM_REGS];

    logic [1:0]    rsp_state_q, rsp_state_d;
    logic [31:0]   rsp_data_q,  rsp_data_d;
    logic          wr_stb_q,    wr_stb_d;
    logic [7:0]    wr_addr_q,   wr_addr_d;
    logic          wr_en;

    // Only a 00 -> non-00 transition seen while idle starts a command.
    assign req      = (state_q == S_IDLE) && (prev_q == 2'b00) && (UART_STATE != 2'b00);
    assign addr_ok  = {1'b0, addr_q} < NUM_REGS_W;
    assign addr_idx = addr_q[AW-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK_100M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state_q <= S_IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (req) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_EXEC;
            S_EXEC:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (registered one stage later) ----------------
    always_comb begin
        rsp_state_d = RSP_NONE;
        rsp_data_d  = rsp_data_q;
        wr_stb_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_en       = 1'b0;
        if (state_q == S_EXEC) begin
            case (class_q)
                CL_WRITE: begin
                    wr_en       = 1'b1;
                    wr_stb_d    = 1'b1;
                    wr_addr_d   = addr_q;
                    rsp_state_d = RSP_WR_OK;
                end
                CL_READ: begin
                    rsp_data_d  = bank[addr_idx];
                    rsp_state_d = RSP_RD_OK;
                end
                default: rsp_state_d = RSP_ERR;
            endcase
        end
    end

    always_comb begin
        class_d = CL_ERR;
        if (cmd_q == CMD_WRITE && addr_ok && addr_q != 8'h00) begin
            class_d = CL_WRITE;
        end else if (cmd_q == CMD_READ && addr_ok) begin
            class_d = CL_READ;
        end
    end

    always_ff @(posedge CLK_100M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            prev_q      <= 2'b00;
            cmd_q       <= 2'b00;
            addr_q      <= 8'h00;
            data_q      <= 32'h0;
            class_q     <= CL_ERR;
            rsp_state_q <= RSP_NONE;
            rsp_data_q  <= 32'h0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= 8'h00;
        end else begin
            prev_q <= UART_STATE;
            if (req) begin
                cmd_q  <= UART_STATE;
                addr_q <= UART_ADDR;
                data_q <= UART_DATA;
            end
            if (state_q == S_CAPTURE) class_q <= class_d;
            rsp_state_q <= rsp_state_d;
            rsp_data_q  <= rsp_data_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    // NOTE: the bank is a handful of flops with a defined reset value, so it is
    // reset explicitly; a RAM-style array would be left unreset instead.
    always_ff @(posedge CLK_100M or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= RST_VALUE;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_en && addr_q == 8'(i)) regs_q[i] <= data_q;
            end
        end
    end

    // Address 0 is the read-only ID word; it also appears on the flat export.
    assign bank[0] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_bank
        assign bank[g] = regs_q[g];
    end
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign REG_Q[32*g +: 32] = bank[g];
    end

    assign REG_STATE   = rsp_state_q;
    assign REG_DATA    = rsp_data_q;
    assign REG_WR_STB  = wr_stb_q;
    assign REG_WR_ADDR = wr_addr_q;

endmodule

// File: tb/tb_uart_reg_bank.sv
// Self-checking bench for uart_reg_bank: directed corner cases plus randomized
// commands scored against a register-array reference model.
module tb_uart_reg_bank;

    localparam int          NUM_REGS  = 8;
    localparam logic [31:0] ID_VALUE  = 32'h5647_4131;
    localparam logic [31:0] RST_VALUE = 32'h0000_0000;

    logic                   clk;
    logic                   rst_n;
    logic [1:0]             uart_state;
    logic [31:0]            uart_data;
    logic [7:0]             uart_addr;
    logic [1:0]             reg_state;
    logic [31:0]            reg_data;
    logic [NUM_REGS*32-1:0] reg_q;
    logic                   reg_wr_stb;
    logic [7:0]             reg_wr_addr;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain array of register contents plus last response data.
    logic [31:0] m_regs [NUM_REGS];
    logic [31:0] m_data;
    logic [7:0]  m_wr_addr;

    uart_reg_bank #(
        .NUM_REGS  (NUM_REGS),
        .ID_VALUE  (ID_VALUE),
        .RST_VALUE (RST_VALUE)
    ) dut (
        .CLK_100M    (clk),
        .SYS_RST_N   (rst_n),
        .UART_STATE  (uart_state),
        .UART_DATA   (uart_data),
        .UART_ADDR   (uart_addr),
        .REG_STATE   (reg_state),
        .REG_DATA    (reg_data),
        .REG_Q       (reg_q),
        .REG_WR_STB  (reg_wr_stb),
        .REG_WR_ADDR (reg_wr_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model_q();
        logic [255:0] f;
        f = '0;
        for (int i = 0; i < NUM_REGS; i++) f[32*i +: 32] = (i == 0) ? ID_VALUE : m_regs[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = RST_VALUE;
        m_data    = 32'h0;
        m_wr_addr = 8'h00;
    endtask

    // Apply one command to the model; returns the expected response code and strobe.
    task automatic model_cmd(input logic [1:0] cmd, input logic [7:0] addr, input logic [31:0] data,
                             output logic [1:0] exp_state, output logic exp_stb);
        exp_stb = 1'b0;
        if (cmd == 2'b11 || int'(addr) >= NUM_REGS || (cmd == 2'b01 && addr == 8'h00)) begin
            exp_state = 2'b11;
        end else if (cmd == 2'b01) begin
            m_regs[addr] = data;
            m_wr_addr    = addr;
            exp_state    = 2'b01;
            exp_stb      = 1'b1;
        end else begin
            m_data    = (addr == 8'h00) ? ID_VALUE : m_regs[addr];
            exp_state = 2'b10;
        end
    endtask

    // Issue one command from idle, hold UART_STATE for 'hold' cycles, and check
    // every cycle up to one past the response.
    task automatic run_cmd(input string tag, input logic [1:0] cmd, input logic [7:0] addr,
                           input logic [31:0] data, input int hold);
        logic [1:0] exp_state;
        logic       exp_stb;
        model_cmd(cmd, addr, data, exp_state, exp_stb);
        @(negedge clk);
        uart_state = cmd;
        uart_addr  = addr;
        uart_data  = data;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                check({tag, " state"},   256'(reg_state),   256'(exp_state));
                check({tag, " stb"},     256'(reg_wr_stb),  256'(exp_stb));
                check({tag, " data"},    256'(reg_data),    256'(m_data));
                check({tag, " wr_addr"}, 256'(reg_wr_addr), 256'(m_wr_addr));
                check({tag, " reg_q"},   256'(reg_q),       model_q());
            end else begin
                check({tag, " quiet state"}, 256'(reg_state),  256'(2'b00));
                check({tag, " quiet stb"},   256'(reg_wr_stb), 256'(1'b0));
            end
            uart_addr = 8'($urandom);
            uart_data = $urandom;
            if (c >= hold) uart_state = 2'b00;
        end
    endtask

    initial begin
        int n_wr, n_rd;
        logic [1:0]  exp_state;
        logic        exp_stb;
        logic [31:0] d;

        rst_n      = 1'b0;
        uart_state = 2'b00;
        uart_addr  = 8'h00;
        uart_data  = 32'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset state",   256'(reg_state),   256'(2'b00));
        check("reset data",    256'(reg_data),    256'(32'h0));
        check("reset stb",     256'(reg_wr_stb),  256'(1'b0));
        check("reset wr_addr", 256'(reg_wr_addr), 256'(8'h00));
        check("reset reg_q",   256'(reg_q),       model_q());
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd("read id",      2'b10, 8'h00, 32'h0, 1);
        run_cmd("write 3",      2'b01, 8'h03, 32'hDEAD_BEEF, 2);
        run_cmd("read 3",       2'b10, 8'h03, 32'h0, 3);
        run_cmd("write 0 err",  2'b01, 8'h00, 32'h1234_5678, 1);
        run_cmd("read 8 err",   2'b10, 8'h08, 32'h0, 2);
        run_cmd("cmd 11 err",   2'b11, 8'h01, 32'hFFFF_FFFF, 1);

        // Long hold of 01 then 01 -> 10 without passing through 00.
        d = $urandom;
        model_cmd(2'b01, 8'h05, d, exp_state, exp_stb);
        n_wr = 0;
        n_rd = 0;
        @(negedge clk);
        uart_state = 2'b01;
        uart_addr  = 8'h05;
        uart_data  = d;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (reg_state == 2'b01) n_wr++;
            if (reg_state == 2'b10) n_rd++;
            if (c == 19) uart_state = 2'b10;
        end
        check("hold wr count", 256'(n_wr), 256'(1));
        check("hold rd count", 256'(n_rd), 256'(0));
        check("hold reg_q",    256'(reg_q), model_q());
        uart_state = 2'b00;
        run_cmd("read 5 after hold", 2'b10, 8'h05, 32'h0, 2);

        // Second request edge while the first command is in EXEC is dropped.
        d = $urandom;
        model_cmd(2'b01, 8'h04, d, exp_state, exp_stb);
        n_wr = 0;
        n_rd = 0;
        @(negedge clk);
        uart_state = 2'b01;
        uart_addr  = 8'h04;
        uart_data  = d;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (reg_state == 2'b01) n_wr++;
            if (reg_state != 2'b00 && reg_state != 2'b01) n_rd++;
            if (c == 1) uart_state = 2'b00;
            if (c == 2) begin
                uart_state = 2'b10;
                uart_addr  = 8'h04;
            end
        end
        check("drop wr count",    256'(n_wr), 256'(1));
        check("drop other count", 256'(n_rd), 256'(0));
        check("drop reg_q",       256'(reg_q), model_q());
        uart_state = 2'b00;
        @(negedge clk);

        // Reset asserted while a write to 0x02 sits in CAPTURE.
        @(negedge clk);
        uart_state = 2'b01;
        uart_addr  = 8'h02;
        uart_data  = 32'hAAAA_5555;
        @(negedge clk);
        rst_n      = 1'b0;
        uart_state = 2'b00;
        model_reset();
        #1;
        check("midrst state", 256'(reg_state), 256'(2'b00));
        check("midrst reg_q", 256'(reg_q),     model_q());
        @(negedge clk);
        rst_n = 1'b1;
        n_wr = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (reg_state != 2'b00 || reg_wr_stb) n_wr++;
        end
        check("midrst no response", 256'(n_wr), 256'(0));
        run_cmd("read 2 after rst", 2'b10, 8'h02, 32'h0, 1);

        // Randomized traffic against the model.
        for (int t = 0; t < 40; t++) begin
            logic [1:0] cmd;
            int         r;
            r   = $urandom_range(0, 9);
            cmd = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
            run_cmd($sformatf("rand%0d", t), cmd, 8'($urandom_range(0, 9)), $urandom,
                    $urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_reg_bank.md
Name: uart_reg_bank

Overview:
- Register-side responder for the UART command path: it accepts read and write commands from the UART control block (state, 32-bit data, 8-bit address).
- It executes each command against a local bank of 32-bit registers and returns a response (state plus 32-bit data) that the control block turns into OK or FAIL text and hex read-back.
- It also exports the register contents and a write strobe to the rest of the design, such as VGA configuration.

Parameters:
- NUM_REGS, 8, number of 32-bit registers at addresses 0..NUM_REGS-1 (range 2..255).
- ID_VALUE, 32'h5647_4131, read-only contents of address 0x00.
- RST_VALUE, 32'h0000_0000, reset value of registers 1..NUM_REGS-1.

Ports:
- CLK_100M  input  1  system clock, 100 MHz.
- SYS_RST_N  input  1  asynchronous active-low reset.
- UART_STATE  input  2  command: 00 idle, 01 write, 10 read, 11 reserved.
- UART_DATA  input  32  write data.
- UART_ADDR  input  8  register address.
- REG_STATE  output  2  response: 00 none, 01 write OK, 10 read data valid, 11 error.
- REG_DATA  output  32  read-back data.
- REG_Q  output  NUM_REGS*32  flat register contents; register n occupies bits [32n+31:32n].
- REG_WR_STB  output  1  one-cycle pulse on each successful write.
- REG_WR_ADDR  output  8  address of the last successful write.

Behaviour:
- Reset (SYS_RST_N low, asynchronous): FSM goes to IDLE; outputs are REG_STATE=00, REG_DATA=0, REG_WR_STB=0, REG_WR_ADDR=0; registers 1..N-1 = RST_VALUE; the previous-state register = 00.
  - Reset mid-command aborts the command: no response and no write.
- Request detection:
  - UART_STATE is registered every cycle.
  - A request is the transition from registered 00 to a non-00 value, sampled in IDLE only.
  - UART_STATE held non-00 for many cycles is a single request.
  - A change from one non-00 value to another (e.g. 01->10) is not a request.
  - A request edge arriving while the FSM is not in IDLE is dropped. The FSM does not re-detect it later unless UART_STATE returns to 00 first.
- FSM states: IDLE -> CAPTURE -> EXEC -> IDLE.
  - IDLE: on a request edge, latch command, address and data; go to CAPTURE.
  - CAPTURE: classify the command (one cycle):
    - error if command = 11;
    - error if address >= NUM_REGS;
    - error if command = write and address = 0x00;
    - otherwise valid.
  - EXEC (one cycle), by classification:
    - write valid: update the register, pulse REG_WR_STB, set REG_WR_ADDR, set REG_STATE=01.
    - read valid: set REG_DATA to the register value and REG_STATE=10.
    - error: set REG_STATE=11 with REG_DATA unchanged.
  - EXEC always returns to IDLE.
- Latency:
  - If the request edge is sampled at clock edge k, REG_STATE is non-00 during the cycle after edge k+2.
  - Turnaround is 3 clocks; back-to-back requests are possible if UART_STATE returns to 00 for at least 1 cycle.
- Response timing:
  - REG_STATE is non-00 for exactly one cycle, then returns to 00.
  - REG_DATA holds its value until the next successful read.
  - REG_WR_STB is coincident with REG_STATE=01.
- Write visibility: the written value appears on REG_Q in the same cycle as REG_WR_STB.
- Address 0x00 always reads ID_VALUE.
- UART_ADDR and UART_DATA are sampled only in IDLE on the request edge; later changes do not affect the command in flight.

Test Plan:
- Reset, then read addr 0x00 -> REG_STATE=10 for 1 cycle, REG_DATA=32'h56474131, 3 clocks after the request edge.
- Write 32'hDEADBEEF to addr 0x03, then read 0x03:
  - write -> REG_STATE=01, REG_WR_STB=1, REG_WR_ADDR=0x03, REG_Q[127:96]=32'hDEADBEEF;
  - read -> REG_STATE=10, REG_DATA=32'hDEADBEEF.
- Error cases, each with no REG_WR_STB and REG_Q unchanged:
  - write 0x00 -> REG_STATE=11;
  - read 0x08 (NUM_REGS=8) -> REG_STATE=11;
  - command 11 -> REG_STATE=11.
- Hold UART_STATE=01 for 20 cycles, then switch it to 10 without passing through 00 -> exactly one write response and no read response.
  - Then 00 for 1 cycle, then 10 -> one read response.
- Assert SYS_RST_N low in the CAPTURE state of a write to 0x02 -> no response; after release, reading 0x02 returns RST_VALUE and REG_STATE=00 while idle.
- Issue a second request edge while in EXEC (toggle 00 for one cycle) -> ignored, so only the first response is produced.
